// File: rtl/pipelined_processor.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_processor
//  Brief    : Three-stage (fetch / execute / writeback) 16-bit CPU with eight
//             registers (r7 = PC), operand forwarding from writeback, and a
//             ready-handshaked single-master data bus.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_processor (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DataIn,
    input  logic [15:0] InstrIn,
    input  logic        DataReady,
    input  logic        Enable,
    output logic [15:0] DataOut,
    output logic [15:0] DataAddr,
    output logic [15:0] InstrAddr,
    output logic        WriteData,
    output logic        ReadData
);

    localparam logic [2:0] c_OP_MV    = 3'b000;
    localparam logic [2:0] c_OP_MVT_B = 3'b001;
    localparam logic [2:0] c_OP_ADD   = 3'b010;
    localparam logic [2:0] c_OP_SUB   = 3'b011;
    localparam logic [2:0] c_OP_LD    = 3'b100;
    localparam logic [2:0] c_OP_ST    = 3'b101;
    localparam logic [2:0] c_OP_AND   = 3'b110;
    localparam logic [2:0] c_OP_CMP   = 3'b111;
    localparam logic [2:0] c_PC       = 3'd7;

    // Architectural state
    logic [15:0]      pc_q, pc_d;
    logic [6:0][15:0] regs_q, regs_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d;

    // EX stage: ex_pc_q is the address of the word currently on InstrIn,
    // ex_valid_q is cleared when that word must be squashed.
    logic             ex_valid_q, ex_valid_d;
    logic [15:0]      ex_pc_q, ex_pc_d;

    // WB stage
    logic             wb_valid_q, wb_valid_d;
    logic             wb_ld_q, wb_ld_d;
    logic             wb_st_q, wb_st_d;
    logic             wb_wr_q, wb_wr_d;
    logic [2:0]       wb_rx_q, wb_rx_d;
    logic [15:0]      wb_res_q, wb_res_d;

    // Bus address / store data, held between accesses
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;

    // Decode fields
    logic [2:0]       w_op;
    logic             w_m;
    logic [2:0]       w_rx;
    logic [2:0]       w_ry;
    logic [8:0]       w_d9;

    logic             w_stall;
    logic             w_wb_pc_load;
    logic             w_ex_live;
    logic             w_fwd_en;
    logic [15:0]      w_fwd_val;
    logic [15:0]      w_pc_plus1;
    logic [15:0]      w_rx_val;
    logic [15:0]      w_ry_val;
    logic [15:0]      w_op2;
    logic [16:0]      w_sum;
    logic [16:0]      w_diff;
    logic [15:0]      w_res;
    logic             w_flag_upd;
    logic             w_carry;
    logic             w_wr_reg;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_is_br;
    logic             w_cond;
    logic             w_take;
    logic [15:0]      w_target;
    logic [15:0]      w_br_target;

    // Operand read: r7 yields own address + 1, otherwise WB result wins over the file.
    function automatic logic [15:0] f_operand(
        input logic [2:0]       idx,
        input logic [6:0][15:0] rf,
        input logic [15:0]      pc_val,
        input logic             fwd_en,
        input logic [2:0]       fwd_idx,
        input logic [15:0]      fwd_val
    );
        logic [15:0] v;
        v = 16'd0;
        if (idx == c_PC) begin
            v = pc_val;
        end else if (fwd_en && (fwd_idx == idx)) begin
            v = fwd_val;
        end else begin
            case (idx)
                3'd0:    v = rf[0];
                3'd1:    v = rf[1];
                3'd2:    v = rf[2];
                3'd3:    v = rf[3];
                3'd4:    v = rf[4];
                3'd5:    v = rf[5];
                3'd6:    v = rf[6];
                default: v = 16'd0;
            endcase
        end
        return v;
    endfunction

    assign w_op = InstrIn[15:13];
    assign w_m  = InstrIn[12];
    assign w_rx = InstrIn[11:9];
    assign w_ry = InstrIn[2:0];
    assign w_d9 = InstrIn[8:0];

    assign w_stall      = ~Enable | (wb_valid_q & (wb_ld_q | wb_st_q) & ~DataReady);
    // A load into r7 redirects from WB, so whatever sits in EX is dead.
    assign w_wb_pc_load = wb_valid_q & wb_ld_q & (wb_rx_q == c_PC);
    assign w_ex_live    = ex_valid_q & ~w_wb_pc_load;
    assign w_fwd_en     = wb_valid_q & (wb_ld_q | wb_wr_q) & (wb_rx_q != c_PC);
    assign w_fwd_val    = wb_ld_q ? DataIn : wb_res_q;
    assign w_pc_plus1   = ex_pc_q + 16'd1;
    assign w_rx_val     = f_operand(w_rx, regs_q, w_pc_plus1, w_fwd_en, wb_rx_q, w_fwd_val);
    assign w_ry_val     = f_operand(w_ry, regs_q, w_pc_plus1, w_fwd_en, wb_rx_q, w_fwd_val);
    assign w_op2        = w_m ? {7'd0, w_d9} : w_ry_val;
    assign w_sum        = {1'b0, w_rx_val} + {1'b0, w_op2};
    assign w_diff       = {1'b0, w_rx_val} + {1'b0, ~w_op2} + 17'd1;
    assign w_br_target  = w_pc_plus1 + {{7{w_d9[8]}}, w_d9};

    // Decode and ALU for the instruction in EX
    always_comb begin
        w_res      = 16'd0;
        w_flag_upd = 1'b0;
        w_carry    = 1'b0;
        w_wr_reg   = 1'b0;
        w_is_ld    = 1'b0;
        w_is_st    = 1'b0;
        w_is_br    = 1'b0;
        case (w_op)
            c_OP_MV: begin
                w_res    = w_op2;
                w_wr_reg = 1'b1;
            end
            c_OP_MVT_B: begin
                if (w_m) begin
                    w_res    = {w_d9[7:0], 8'h00};
                    w_wr_reg = 1'b1;
                end else begin
                    w_is_br = 1'b1;
                end
            end
            c_OP_ADD: begin
                w_res      = w_sum[15:0];
                w_carry    = w_sum[16];
                w_flag_upd = 1'b1;
                w_wr_reg   = 1'b1;
            end
            c_OP_SUB: begin
                w_res      = w_diff[15:0];
                w_carry    = w_diff[16];
                w_flag_upd = 1'b1;
                w_wr_reg   = 1'b1;
            end
            c_OP_LD:  w_is_ld = 1'b1;
            c_OP_ST:  w_is_st = 1'b1;
            c_OP_AND: begin
                w_res      = w_rx_val & w_op2;
                w_flag_upd = 1'b1;
                w_wr_reg   = 1'b1;
            end
            c_OP_CMP: begin
                w_res      = w_diff[15:0];
                w_carry    = w_diff[16];
                w_flag_upd = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch condition evaluated against the committed flags
    always_comb begin
        case (w_rx)
            3'd0:    w_cond = 1'b1;
            3'd1:    w_cond = z_q;
            3'd2:    w_cond = ~z_q;
            3'd3:    w_cond = ~c_q;
            3'd4:    w_cond = c_q;
            3'd5:    w_cond = ~n_q;
            3'd6:    w_cond = n_q;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_take   = (w_wr_reg && (w_rx == c_PC)) || (w_is_br && w_cond);
    assign w_target = w_wr_reg ? w_res : w_br_target;

    // Next-state for every pipeline register; a stall leaves all of them as is
    always_comb begin
        pc_d       = pc_q;
        regs_d     = regs_q;
        z_d        = z_q;
        n_d        = n_q;
        c_d        = c_q;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        wb_valid_d = wb_valid_q;
        wb_ld_d    = wb_ld_q;
        wb_st_d    = wb_st_q;
        wb_wr_d    = wb_wr_q;
        wb_rx_d    = wb_rx_q;
        wb_res_d   = wb_res_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        if (!w_stall) begin
            pc_d       = pc_q + 16'd1;
            ex_pc_d    = pc_q;
            ex_valid_d = 1'b1;
            wb_valid_d = 1'b0;
            wb_ld_d    = 1'b0;
            wb_st_d    = 1'b0;
            wb_wr_d    = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (w_fwd_en && (wb_rx_q == 3'(i))) begin
                    regs_d[i] = w_fwd_val;
                end
            end
            if (w_ex_live) begin
                if (w_flag_upd) begin
                    z_d = (w_res == 16'd0);
                    n_d = w_res[15];
                    c_d = w_carry;
                end
                if (w_wr_reg || w_is_ld || w_is_st) begin
                    wb_valid_d = 1'b1;
                    wb_ld_d    = w_is_ld;
                    wb_st_d    = w_is_st;
                    wb_wr_d    = w_wr_reg;
                    wb_rx_d    = w_rx;
                    wb_res_d   = w_res;
                end
                if (w_is_ld || w_is_st) begin
                    addr_d = w_ry_val;
                end
                if (w_is_st) begin
                    dout_d = w_rx_val;
                end
                if (w_take) begin
                    pc_d       = w_target;
                    ex_valid_d = 1'b0;
                end
            end
            if (w_wb_pc_load) begin
                pc_d       = DataIn;
                ex_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q       <= 16'd0;
            regs_q     <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= 16'd0;
            wb_valid_q <= 1'b0;
            wb_ld_q    <= 1'b0;
            wb_st_q    <= 1'b0;
            wb_wr_q    <= 1'b0;
            wb_rx_q    <= 3'd0;
            wb_res_q   <= 16'd0;
            addr_q     <= 16'd0;
            dout_q     <= 16'd0;
        end else begin
            pc_q       <= pc_d;
            regs_q     <= regs_d;
            z_q        <= z_d;
            n_q        <= n_d;
            c_q        <= c_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            wb_valid_q <= wb_valid_d;
            wb_ld_q    <= wb_ld_d;
            wb_st_q    <= wb_st_d;
            wb_wr_q    <= wb_wr_d;
            wb_rx_q    <= wb_rx_d;
            wb_res_q   <= wb_res_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
        end
    end

    // While stalled, re-fetch the EX word so InstrIn presents it again afterwards
    assign InstrAddr = w_stall ? ex_pc_q : pc_q;
    assign ReadData  = wb_valid_q & wb_ld_q;
    assign WriteData = wb_valid_q & wb_st_q;
    assign DataAddr  = addr_q;
    assign DataOut   = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_processor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_processor
//  Brief    : Directed self-checking bench for pipelined_processor with a
//             synchronous instruction ROM and a wait-state data bus model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_processor;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b1;
    logic [15:0] DataIn;
    logic [15:0] InstrIn = 16'd0;
    logic        DataReady;
    logic [15:0] DataOut;
    logic [15:0] DataAddr;
    logic [15:0] InstrAddr;
    logic        WriteData;
    logic        ReadData;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] imem [0:63];
    logic [15:0] dmem [0:15];
    int          wait_cfg  = 0;
    int          wait_left = 0;
    logic [15:0] st_addr [0:15];
    logic [15:0] st_data [0:15];
    int          st_cnt = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVB = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;

    always #5 Clock = ~Clock;

    pipelined_processor dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .DataIn    (DataIn),
        .InstrIn   (InstrIn),
        .DataReady (DataReady),
        .Enable    (Enable),
        .DataOut   (DataOut),
        .DataAddr  (DataAddr),
        .InstrAddr (InstrAddr),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                        input logic [2:0] rx, input logic [8:0] d);
        return {op, m, rx, d};
    endfunction

    localparam logic [15:0] NOP  = {OP_MVB, 1'b0, 3'd7, 9'd0};      // branch-never
    localparam logic [15:0] HALT = {OP_MVB, 1'b0, 3'd0, 9'h1FF};    // branch-to-self

    // Synchronous-read instruction ROM
    always @(posedge Clock) InstrIn <= imem[InstrAddr[5:0]];

    // Data bus: wait_cfg cycles of DataReady=0 per access, stores logged on completion
    assign DataIn    = dmem[DataAddr[3:0]];
    assign DataReady = (wait_left == 0);
    always @(posedge Clock) begin
        if (Reset) begin
            st_cnt    <= 0;
            wait_left <= wait_cfg;
        end else if (ReadData || WriteData) begin
            if (wait_left != 0) begin
                wait_left <= wait_left - 1;
            end else begin
                if (WriteData && st_cnt < 16) begin
                    st_addr[st_cnt] <= DataAddr;
                    st_data[st_cnt] <= DataOut;
                    st_cnt          <= st_cnt + 1;
                end
                wait_left <= wait_cfg;
            end
        end else begin
            wait_left <= wait_cfg;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        for (int i = 0; i < 16; i++) dmem[i] = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge Clock);
    endtask

    task automatic test_reset();
        clear_mem();
        wait_cfg = 0;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_cmp++; if (InstrAddr !== 16'd0) begin n_bad++; $display("FAIL reset_instraddr got %h exp 0000", InstrAddr); end
        n_cmp++; if (ReadData !== 1'b0 || WriteData !== 1'b0) begin n_bad++; $display("FAIL reset_req got rd=%b wr=%b exp 0/0", ReadData, WriteData); end
        n_cmp++; if (DataAddr !== 16'd0 || DataOut !== 16'd0) begin n_bad++; $display("FAIL reset_bus got addr=%h dout=%h exp 0000/0000", DataAddr, DataOut); end
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (InstrAddr !== 16'(k)) begin n_bad++; $display("FAIL reset_fetch_seq[%0d] got %h exp %h", k, InstrAddr, 16'(k)); end
            @(negedge Clock);
        end
    endtask

    task automatic test_forward_store();
        int k;
        clear_mem();
        imem[0] = enc(OP_MV,  1'b1, 3'd0, 9'd5);
        imem[1] = enc(OP_ADD, 1'b1, 3'd0, 9'd3);
        imem[2] = enc(OP_MVB, 1'b1, 3'd1, 9'h010);
        imem[3] = enc(OP_ST,  1'b0, 3'd0, 9'd1);
        imem[4] = HALT;
        wait_cfg = 0;
        do_reset();
        k = 0;
        while (WriteData !== 1'b1 && k < 40) begin @(negedge Clock); k++; end
        n_cmp++; if (WriteData !== 1'b1) begin n_bad++; $display("FAIL fwd_store_req got wr=%b exp 1", WriteData); end
        n_cmp++; if (DataAddr !== 16'h1000) begin n_bad++; $display("FAIL fwd_store_addr got %h exp 1000", DataAddr); end
        n_cmp++; if (DataOut !== 16'h0008) begin n_bad++; $display("FAIL fwd_store_data got %h exp 0008", DataOut); end
        run(10);
        n_cmp++; if (st_cnt !== 1) begin n_bad++; $display("FAIL fwd_store_count got %0d exp 1", st_cnt); end
    endtask

    task automatic test_wait_states();
        int k;
        clear_mem();
        imem[0] = enc(OP_MV,  1'b1, 3'd0, 9'd5);
        imem[1] = enc(OP_ADD, 1'b1, 3'd0, 9'd3);
        imem[2] = enc(OP_MVB, 1'b1, 3'd1, 9'h010);
        imem[3] = enc(OP_ST,  1'b0, 3'd0, 9'd1);
        imem[4] = enc(OP_ADD, 1'b1, 3'd0, 9'd1);
        imem[5] = enc(OP_ST,  1'b0, 3'd0, 9'd1);
        imem[6] = HALT;
        wait_cfg = 3;
        do_reset();
        k = 0;
        while (WriteData !== 1'b1 && k < 40) begin @(negedge Clock); k++; end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (WriteData !== 1'b1 || DataAddr !== 16'h1000 || DataOut !== 16'h0008) begin
                n_bad++; $display("FAIL wait_hold[%0d] got wr=%b addr=%h dout=%h exp 1/1000/0008", c, WriteData, DataAddr, DataOut);
            end
            n_cmp++;
            if (InstrAddr !== ((c < 3) ? 16'd4 : 16'd5)) begin
                n_bad++; $display("FAIL wait_instraddr[%0d] got %h exp %h", c, InstrAddr, (c < 3) ? 16'd4 : 16'd5);
            end
            @(negedge Clock);
        end
        n_cmp++; if (WriteData !== 1'b0) begin n_bad++; $display("FAIL wait_gap got wr=%b exp 0", WriteData); end
        run(15);
        n_cmp++; if (st_cnt !== 2) begin n_bad++; $display("FAIL wait_store_count got %0d exp 2", st_cnt); end
        n_cmp++; if (st_data[0] !== 16'h0008 || st_data[1] !== 16'h0009) begin
            n_bad++; $display("FAIL wait_store_data got %h,%h exp 0008,0009", st_data[0], st_data[1]);
        end
    endtask

    task automatic test_load_use();
        int k;
        clear_mem();
        dmem[0] = 16'h1234;
        imem[0] = enc(OP_MVB, 1'b1, 3'd1, 9'h010);
        imem[1] = enc(OP_LD,  1'b0, 3'd2, 9'd1);
        imem[2] = enc(OP_ADD, 1'b1, 3'd2, 9'd1);
        imem[3] = enc(OP_ST,  1'b0, 3'd2, 9'd1);
        imem[4] = HALT;
        wait_cfg = 2;
        do_reset();
        k = 0;
        while (ReadData !== 1'b1 && k < 40) begin @(negedge Clock); k++; end
        n_cmp++; if (ReadData !== 1'b1 || DataAddr !== 16'h1000) begin
            n_bad++; $display("FAIL load_req got rd=%b addr=%h exp 1/1000", ReadData, DataAddr);
        end
        run(20);
        n_cmp++; if (st_cnt !== 1) begin n_bad++; $display("FAIL load_use_count got %0d exp 1", st_cnt); end
        n_cmp++; if (st_addr[0] !== 16'h1000 || st_data[0] !== 16'h1235) begin
            n_bad++; $display("FAIL load_use_data got addr=%h dout=%h exp 1000/1235", st_addr[0], st_data[0]);
        end
    endtask

    task automatic test_branch(input logic taken);
        clear_mem();
        imem[0] = enc(OP_MVB, 1'b1, 3'd1, 9'h010);
        imem[1] = enc(OP_MV,  1'b1, 3'd3, 9'd2);
        imem[2] = enc(OP_SUB, 1'b1, 3'd3, 9'd2);
        imem[3] = enc(OP_MVB, 1'b0, taken ? 3'd1 : 3'd2, 9'd1);
        imem[4] = enc(OP_MV,  1'b1, 3'd4, 9'd7);
        imem[5] = enc(OP_MV,  1'b1, 3'd5, 9'd9);
        imem[6] = enc(OP_ST,  1'b0, 3'd4, 9'd1);
        imem[7] = enc(OP_ST,  1'b0, 3'd5, 9'd1);
        imem[8] = HALT;
        wait_cfg = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (!taken) begin
                n_cmp++; if (InstrAddr !== 16'(k)) begin n_bad++; $display("FAIL bne_fetch_seq[%0d] got %h exp %h", k, InstrAddr, 16'(k)); end
            end
            @(negedge Clock);
        end
        run(12);
        n_cmp++; if (st_cnt !== 2) begin n_bad++; $display("FAIL branch_count(t=%b) got %0d exp 2", taken, st_cnt); end
        n_cmp++; if (st_data[0] !== (taken ? 16'h0000 : 16'h0007)) begin
            n_bad++; $display("FAIL branch_r4(t=%b) got %h exp %h", taken, st_data[0], taken ? 16'h0000 : 16'h0007);
        end
        n_cmp++; if (st_data[1] !== 16'h0009) begin n_bad++; $display("FAIL branch_r5(t=%b) got %h exp 0009", taken, st_data[1]); end
    endtask

    task automatic test_jump_r7();
        logic [15:0] exp_seq [0:3];
        exp_seq[0] = 16'd0; exp_seq[1] = 16'd1; exp_seq[2] = 16'd6; exp_seq[3] = 16'd7;
        clear_mem();
        imem[0] = enc(OP_MV, 1'b1, 3'd7, 9'd6);
        imem[1] = enc(OP_MV, 1'b1, 3'd0, 9'd3);
        imem[6] = enc(OP_ST, 1'b0, 3'd0, 9'd1);
        imem[7] = HALT;
        wait_cfg = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (InstrAddr !== exp_seq[k]) begin n_bad++; $display("FAIL jump_seq[%0d] got %h exp %h", k, InstrAddr, exp_seq[k]); end
            @(negedge Clock);
        end
        run(8);
        n_cmp++; if (st_cnt !== 1 || st_data[0] !== 16'h0000) begin
            n_bad++; $display("FAIL jump_squash got cnt=%0d dout=%h exp 1/0000", st_cnt, st_data[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        int k;
        clear_mem();
        imem[0] = enc(OP_MVB, 1'b1, 3'd1, 9'h010);
        imem[1] = enc(OP_ST,  1'b0, 3'd0, 9'd1);
        imem[2] = HALT;
        wait_cfg = 5;
        do_reset();
        k = 0;
        while (WriteData !== 1'b1 && k < 40) begin @(negedge Clock); k++; end
        n_cmp++; if (WriteData !== 1'b1) begin n_bad++; $display("FAIL midreset_req got wr=%b exp 1", WriteData); end
        Reset = 1'b1;
        #1;
        n_cmp++; if (WriteData !== 1'b0 || DataAddr !== 16'h0000) begin
            n_bad++; $display("FAIL midreset_drop got wr=%b addr=%h exp 0/0000", WriteData, DataAddr);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_store();
        test_wait_states();
        test_load_use();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump_r7();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_processor.md
# pipelined_processor

Three-stage pipelined 16-bit CPU. It fetches from a synchronous-read instruction memory and accesses data through a single-master read/write bus with a ready handshake. It sits between the instruction ROM and the Avalon-style data bus adapter in the system top level. Eight 16-bit registers r0–r7, with r7 as the program counter; word addressing throughout.

## Interface
- No parameters.
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- DataIn  in  16  load data from the data bus.
- InstrIn  in  16  instruction word; reflects the InstrAddr of the previous cycle.
- DataReady  in  1  high = current bus read/write completes this cycle (inverse of bus waitrequest).
- Enable  in  1  global clock enable; 0 freezes all state.
- DataOut  out  16  store data.
- DataAddr  out  16  data bus address.
- InstrAddr  out  16  instruction fetch address.
- WriteData  out  1  store request.
- ReadData  out  1  load request.

## Operation
- Encoding: [15:13] opcode, [12] M (immediate select), [11:9] rX (destination/cond), [8:0] D.
- Op2 = M ? zero-extended D[8:0] : rY (D[2:0]).
- Opcode 000 mv: rX ← Op2.
- Opcode 001, M=1 mvt: rX ← {D[7:0], 8'h00}.
- Opcode 001, M=0 b{cond}: if the condition in rX holds, PC ← (branch address + 1) + sign-extend(D[8:0]).
- Opcode 010 add: rX ← rX + Op2.
- Opcode 011 sub: rX ← rX − Op2.
- Opcode 100 ld: rX ← mem[rY].
- Opcode 101 st: mem[rY] ← rX.
- Opcode 110 and: rX ← rX & Op2.
- Opcode 111 cmp: computes rX − Op2, no register write.
- Flags z, n, c: updated only by add, sub, and, cmp.
  - z = result==0; n = result[15].
  - c = carry-out (add) or NOT borrow (sub/cmp).
  - and clears c.
- Branch conditions: 000 always, 001 eq (z), 010 ne (!z), 011 cc (!c), 100 cs (c), 101 pl (!n), 110 mi (n). 111 is never taken, so the instruction acts as a nop.
- Reading r7 as an operand yields the instruction's own address + 1.
- Writing r7 (mv/add/sub/and/mvt) is a jump.
- Stages:
  - F: drive InstrAddr = PC; PC ← PC+1.
  - EX: decode InstrIn, read operands, execute ALU, resolve branch/r7 write, latch result/address/store data into the WB register.
  - WB: perform the bus access if ld/st; write back rX.
- Forwarding: an EX operand matching the WB destination takes the WB value. For a ld in WB that value is DataIn, used only in the completing cycle.
- Bus: while a ld/st is in WB, ReadData or WriteData is high with DataAddr = rY (and DataOut = rX for st). These stay stable until DataReady=1. The access completes, and ld writes back, on the edge where DataReady=1.
- Outside ld/st, ReadData=WriteData=0 and DataAddr/DataOut hold their last values.

## Timing
- Reset: PC=0, r0–r6=0, flags=0, EX/WB empty (bubble). InstrAddr=0, ReadData=WriteData=0, DataAddr=DataOut=0.
- First instruction (address 0) enters EX on the first cycle after Reset falls.
- Throughput is one instruction per cycle without hazards.
- Stall = (WB holds ld/st AND DataReady=0) OR Enable=0. During a stall all pipeline registers, PC, registers and flags hold.
- During a stall, InstrAddr = address of the EX instruction, so InstrIn re-presents it after the stall.
- Taken branch or r7 write in EX: F is loaded with the target next cycle, and the instruction arriving on InstrIn in that cycle is squashed. Penalty: 1 bubble.
- ld to r7: resolved in WB; squash EX and the in-flight fetch. Penalty: 2 bubbles.
- A squashed slot performs no register, flag or bus effect.
- Back-to-back ld/st issue one bus transaction each; there is no idle cycle required between them.
- Reset mid-access drops the request immediately (asynchronous).

## Test plan
- Reset: hold Reset 2 cycles → InstrAddr=0, ReadData=WriteData=0. After release, InstrAddr steps 0,1,2,3 on consecutive cycles.
- Forward + store: program mv r0,#5; add r0,#3; mvt r1,#0x10; st r0,[r1] → WriteData=1, DataAddr=0x1000, DataOut=0x0008.
- Wait states: bus holds DataReady=0 for 3 cycles on that st → DataAddr/DataOut/WriteData stay constant for 4 cycles, InstrAddr stays frozen, and the next instruction executes exactly once.
- Load-use: memory returns 0x1234 at 0x1000; ld r2,[r1]; add r2,#1; st r2,[r1] → DataOut=0x1235.
- Branch: mv r3,#2; sub r3,#2; beq +1; mv r4,#7; mv r5,#9; st r4,[r1] → DataOut=0x0000 and r5=9. This proves the branch is taken and the squashed slot has no effect.
- Not-taken branch: same program with bne → DataOut=0x0007, no bubble in the InstrAddr sequence.
